wb_unit: RTL and testbench



---
 rtl/wb_unit.sv | 129 ++++++++++++
 tb/tb_wb_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - write-back stage: register-file write port, load wait, halt/timeout tracking
module wb_unit #(
   parameter int DATA_W      = 16,
   parameter int REG_AW      = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_RegWrite,
   input  logic              in_mem_to_reg,
   input  logic [REG_AW-1:0] in_reg_rd,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic              in_HALT,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              RegWrite_out,
   output logic [REG_AW-1:0] reg_rd_wb,
   output logic [DATA_W-1:0] reg_rd_data,
   output logic [REG_AW-1:0] MEM_WB_reg_rd,
   output logic              wb_stall,
   output logic              halted,
   output logic              mem_timeout,
   output logic [15:0]       retired_count
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_MEM = 2'd1,
      S_HALTED   = 2'd2,
      S_ERROR    = 2'd3
   } state_t;

   // Last wait-counter value before a missing rvalid becomes a timeout
   localparam logic [7:0] LP_CNT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t              r_state;
   logic [7:0]          r_wait_cnt;
   logic [REG_AW-1:0]   r_load_rd;
   logic                r_regwrite;
   logic [REG_AW-1:0]   r_rd_wb;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_halted;
   logic                r_timeout;
   logic [15:0]         r_count;

   logic                w_accept;
   logic                w_is_load;
   logic                w_alu_we;
   logic                w_load_we;

   assign in_ready  = (r_state == S_IDLE) & ~rst;
   assign w_accept  = in_valid & in_ready;
   assign w_is_load = in_mem_to_reg & in_RegWrite;
   // Writes to R0 are dropped but the instruction still retires
   assign w_alu_we  = in_RegWrite & (in_reg_rd != '0);
   assign w_load_we = (r_load_rd != '0);

   // Sequencing of retire, load wait, halt and timeout with registered write-port outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
         r_load_rd  <= '0;
         r_regwrite <= 1'b0;
         r_rd_wb    <= '0;
         r_rd_data  <= '0;
         r_halted   <= 1'b0;
         r_timeout  <= 1'b0;
         r_count    <= '0;
      end else begin
         r_regwrite <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (in_HALT) begin
                     r_state  <= S_HALTED;
                     r_halted <= 1'b1;
                     r_count  <= r_count + 16'd1;
                  end else if (w_is_load) begin
                     r_state    <= S_WAIT_MEM;
                     r_load_rd  <= in_reg_rd;
                     r_wait_cnt <= '0;
                  end else begin
                     r_count <= r_count + 16'd1;
                     if (w_alu_we) begin
                        r_regwrite <= 1'b1;
                        r_rd_wb    <= in_reg_rd;
                        r_rd_data  <= in_alu_result;
                     end
                  end
               end
            end
            S_WAIT_MEM: begin
               if (mem_rvalid) begin
                  r_state <= S_IDLE;
                  r_count <= r_count + 16'd1;
                  if (w_load_we) begin
                     r_regwrite <= 1'b1;
                     r_rd_wb    <= r_load_rd;
                     r_rd_data  <= mem_rdata;
                  end
               end else if (r_wait_cnt == LP_CNT_LAST) begin
                  r_state   <= S_ERROR;
                  r_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            S_HALTED: r_state <= S_HALTED;
            S_ERROR:  r_state <= S_ERROR;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign wb_stall      = (r_state == S_WAIT_MEM);
   // Hazard view: the outstanding load target, else the register being written this cycle
   assign MEM_WB_reg_rd = (r_state == S_WAIT_MEM) ? r_load_rd :
                          (r_regwrite ? r_rd_wb : '0);
   assign RegWrite_out  = r_regwrite;
   assign reg_rd_wb     = r_rd_wb;
   assign reg_rd_data   = r_rd_data;
   assign halted        = r_halted;
   assign mem_timeout   = r_timeout;
   assign retired_count = r_count;

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - directed scoreboard bench for wb_unit
`timescale 1ns/1ps
module tb_wb_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_RegWrite;
   logic        in_mem_to_reg;
   logic [3:0]  in_reg_rd;
   logic [15:0] in_alu_result;
   logic        in_HALT;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic        RegWrite_out;
   logic [3:0]  reg_rd_wb;
   logic [15:0] reg_rd_data;
   logic [3:0]  MEM_WB_reg_rd;
   logic        wb_stall;
   logic        halted;
   logic        mem_timeout;
   logic [15:0] retired_count;

   typedef struct packed {
      logic [3:0]  rd;
      logic [15:0] data;
   } wb_t;

   wb_t         exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_count;

   wb_unit #(.DATA_W(16), .REG_AW(4), .MEM_TIMEOUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_RegWrite   (in_RegWrite),
      .in_mem_to_reg (in_mem_to_reg),
      .in_reg_rd     (in_reg_rd),
      .in_alu_result (in_alu_result),
      .in_HALT       (in_HALT),
      .mem_rdata     (mem_rdata),
      .mem_rvalid    (mem_rvalid),
      .RegWrite_out  (RegWrite_out),
      .reg_rd_wb     (reg_rd_wb),
      .reg_rd_data   (reg_rd_data),
      .MEM_WB_reg_rd (MEM_WB_reg_rd),
      .wb_stall      (wb_stall),
      .halted        (halted),
      .mem_timeout   (mem_timeout),
      .retired_count (retired_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wb(input logic [3:0] rd, input logic [15:0] data);
      wb_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic set_in(input logic v, input logic rw, input logic m2r,
                         input logic [3:0] rd, input logic [15:0] alu, input logic hlt);
      in_valid      = v;
      in_RegWrite   = rw;
      in_mem_to_reg = m2r;
      in_reg_rd     = rd;
      in_alu_result = alu;
      in_HALT       = hlt;
   endtask

   // Scoreboard: every write pulse must match the oldest expected write
   always @(negedge clk) begin
      if (rst) begin
         chk("no_write_in_reset", 32'(RegWrite_out), 32'd0);
      end else if (RegWrite_out) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(RegWrite_out), 32'd0);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_rd", 32'(reg_rd_wb), 32'(e.rd));
            chk("wb_data", 32'(reg_rd_data), 32'(e.data));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] d;
      rst = 1'b1;
      mem_rdata = '0;
      mem_rvalid = 1'b0;
      set_in(0, 0, 0, 4'd0, 16'h0, 0);
      exp_count = '0;

      // Reset state
      repeat (3) cyc();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_wb_stall", 32'(wb_stall), 32'd0);
      chk("rst_regwrite", 32'(RegWrite_out), 32'd0);
      chk("rst_rd_wb", 32'(reg_rd_wb), 32'd0);
      chk("rst_rd_data", 32'(reg_rd_data), 32'd0);
      chk("rst_memwb", 32'(MEM_WB_reg_rd), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_timeout", 32'(mem_timeout), 32'd0);
      chk("rst_count", 32'(retired_count), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // ALU retire, rd=3
      set_in(1, 1, 0, 4'd3, 16'h1234, 0);
      push_wb(4'd3, 16'h1234);
      exp_count++;
      cyc();
      chk("alu_regwrite", 32'(RegWrite_out), 32'd1);
      chk("alu_rd", 32'(reg_rd_wb), 32'd3);
      chk("alu_data", 32'(reg_rd_data), 32'h1234);
      chk("alu_memwb", 32'(MEM_WB_reg_rd), 32'd3);
      chk("alu_count", 32'(retired_count), 32'(exp_count));

      // Four back-to-back ALU retires
      for (int i = 0; i < 4; i++) begin
         d = 16'($urandom);
         set_in(1, 1, 0, 4'(i + 10), d, 0);
         push_wb(4'(i + 10), d);
         exp_count++;
         cyc();
         chk("b2b_regwrite", 32'(RegWrite_out), 32'd1);
         chk("b2b_memwb", 32'(MEM_WB_reg_rd), 32'(i + 10));
      end
      set_in(0, 0, 0, 4'd0, 16'h0, 0);
      cyc();
      chk("idle_regwrite", 32'(RegWrite_out), 32'd0);
      chk("idle_hold_rd", 32'(reg_rd_wb), 32'd13);
      chk("idle_memwb", 32'(MEM_WB_reg_rd), 32'd0);
      chk("b2b_count", 32'(retired_count), 32'(exp_count));

      // Non-writing instruction retires without a write
      set_in(1, 0, 0, 4'd9, 16'hAAAA, 0);
      exp_count++;
      cyc();
      set_in(0, 0, 0, 4'd0, 16'h0, 0);
      chk("nw_regwrite", 32'(RegWrite_out), 32'd0);
      chk("nw_memwb", 32'(MEM_WB_reg_rd), 32'd0);
      chk("nw_hold_rd", 32'(reg_rd_wb), 32'd13);
      chk("nw_count", 32'(retired_count), 32'(exp_count));

      // Load rd=5, rvalid in accept cycle ignored, real rvalid three cycles later
      set_in(1, 1, 1, 4'd5, 16'h0000, 0);
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hDEAD;
      cyc();
      set_in(0, 0, 0, 4'd0, 16'h0, 0);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("ld_stall", 32'(wb_stall), 32'd1);
         chk("ld_in_ready", 32'(in_ready), 32'd0);
         chk("ld_memwb", 32'(MEM_WB_reg_rd), 32'd5);
         chk("ld_regwrite", 32'(RegWrite_out), 32'd0);
         if (i == 2) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'hBEEF;
            push_wb(4'd5, 16'hBEEF);
            exp_count++;
         end
         cyc();
      end
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0;
      chk("ld_wr_regwrite", 32'(RegWrite_out), 32'd1);
      chk("ld_wr_in_ready", 32'(in_ready), 32'd1);
      chk("ld_wr_stall", 32'(wb_stall), 32'd0);
      chk("ld_wr_memwb", 32'(MEM_WB_reg_rd), 32'd5);
      chk("ld_wr_count", 32'(retired_count), 32'(exp_count));
      // New accept in the load's write cycle
      set_in(1, 1, 0, 4'd2, 16'h55AA, 0);
      push_wb(4'd2, 16'h55AA);
      exp_count++;
      cyc();
      set_in(0, 0, 0, 4'd0, 16'h0, 0);
      chk("ld_next_regwrite", 32'(RegWrite_out), 32'd1);
      chk("ld_next_count", 32'(retired_count), 32'(exp_count));
      cyc();

      // Timeout: four WAIT_MEM cycles then ERROR
      set_in(1, 1, 1, 4'd7, 16'h0, 0);
      cyc();
      set_in(0, 0, 0, 4'd0, 16'h0, 0);
      for (int i = 0; i < 4; i++) begin
         chk("to_stall", 32'(wb_stall), 32'd1);
         chk("to_memwb", 32'(MEM_WB_reg_rd), 32'd7);
         chk("to_flag_early", 32'(mem_timeout), 32'd0);
         cyc();
      end
      chk("to_flag", 32'(mem_timeout), 32'd1);
      chk("to_err_stall", 32'(wb_stall), 32'd0);
      chk("to_err_in_ready", 32'(in_ready), 32'd0);
      chk("to_err_memwb", 32'(MEM_WB_reg_rd), 32'd0);
      chk("to_err_count", 32'(retired_count), 32'(exp_count));
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h1111;
      cyc();
      mem_rvalid = 1'b0;
      cyc();
      chk("late_rv_regwrite", 32'(RegWrite_out), 32'd0);
      chk("late_rv_count", 32'(retired_count), 32'(exp_count));
      chk("late_rv_flag", 32'(mem_timeout), 32'd1);

      // Reset out of ERROR
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_count = '0;
      #1;
      chk("err_rst_flag", 32'(mem_timeout), 32'd0);
      chk("err_rst_in_ready", 32'(in_ready), 32'd1);

      // HLT: no write, sticky halted, in_ready held low
      set_in(1, 1, 0, 4'd4, 16'h4444, 1);
      exp_count++;
      cyc();
      set_in(1, 1, 0, 4'd8, 16'h8888, 0);
      chk("hlt_halted", 32'(halted), 32'd1);
      chk("hlt_regwrite", 32'(RegWrite_out), 32'd0);
      chk("hlt_count", 32'(retired_count), 32'(exp_count));
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("hlt_in_ready", 32'(in_ready), 32'd0);
      end
      chk("hlt_count_hold", 32'(retired_count), 32'(exp_count));
      chk("hlt_sticky", 32'(halted), 32'd1);
      set_in(0, 0, 0, 4'd0, 16'h0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("hlt_rst_halted", 32'(halted), 32'd0);
      chk("hlt_rst_in_ready", 32'(in_ready), 32'd0);
      cyc();
      rst = 1'b0;
      exp_count = '0;
      #1;
      chk("hlt_rel_in_ready", 32'(in_ready), 32'd1);

      // Wrap: 65535 non-writing retires, then an R0 write
      set_in(1, 0, 0, 4'd1, 16'h0, 0);
      repeat (65535) cyc();
      exp_count = 16'hFFFF;
      chk("wrap_pre_count", 32'(retired_count), 32'(exp_count));
      set_in(1, 1, 0, 4'd0, 16'h1111, 0);
      exp_count++;
      cyc();
      set_in(0, 0, 0, 4'd0, 16'h0, 0);
      chk("r0_regwrite", 32'(RegWrite_out), 32'd0);
      chk("r0_memwb", 32'(MEM_WB_reg_rd), 32'd0);
      chk("wrap_count", 32'(retired_count), 32'(exp_count));
      cyc();

      // Async reset mid-load with rvalid pending
      set_in(1, 1, 1, 4'd6, 16'h0, 0);
      cyc();
      set_in(0, 0, 0, 4'd0, 16'h0, 0);
      chk("ar_stall", 32'(wb_stall), 32'd1);
      chk("ar_memwb", 32'(MEM_WB_reg_rd), 32'd6);
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h7777;
      #2;
      rst = 1'b1;
      #1;
      chk("ar_memwb_zero", 32'(MEM_WB_reg_rd), 32'd0);
      chk("ar_stall_zero", 32'(wb_stall), 32'd0);
      chk("ar_in_ready_zero", 32'(in_ready), 32'd0);
      chk("ar_regwrite_zero", 32'(RegWrite_out), 32'd0);
      chk("ar_count_zero", 32'(retired_count), 32'd0);
      cyc();
      chk("ar_edge_regwrite", 32'(RegWrite_out), 32'd0);
      mem_rvalid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("ar_rel_in_ready", 32'(in_ready), 32'd1);
      chk("ar_rel_stall", 32'(wb_stall), 32'd0);
      cyc();
      chk("ar_post_regwrite", 32'(RegWrite_out), 32'd0);
      chk("ar_post_count", 32'(retired_count), 32'd0);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
